// File: rtl/fifo_read_stream_adapter_pkg.sv
// Shared constants for the read-domain dataflow blocks downstream of the hard FIFO.
package fifo_read_stream_adapter_pkg;

  // Hard FIFO in standard mode with its output register enabled.
  localparam int unsigned HARD_FIFO_READ_LATENCY = 2;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Circular skid buffer with a registered head word and occupancy count.
module stream_skid_buffer
  import fifo_read_stream_adapter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_occ,
  output logic                     o_overflow_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $fatal(1, "stream_skid_buffer: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_occ;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_occ_after_pop;
  logic [CNT_W-1:0] w_occ_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_full       = (r_occ == CNT_W'(DEPTH));
  assign w_pop        = i_pop && r_valid;
  assign w_push       = i_push && !w_full;
  assign o_overflow_c = i_push && w_full;

  // Head is re-selected from the post-pop state so out_data stays a flop output.
  always_comb begin
    w_occ_after_pop = r_occ - CNT_W'(w_pop);
    w_occ_nxt       = w_occ_after_pop + CNT_W'(w_push);
    w_rd_ptr_nxt    = r_rd_ptr + PTR_W'(w_pop);
    w_head_nxt      = r_head;
    if (w_occ_after_pop == '0) begin
      if (w_push) w_head_nxt = i_push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_occ    <= w_occ_nxt;
      r_valid  <= (w_occ_nxt != '0);
      r_head   <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// Turns the hard FIFO's fixed-latency read port into a valid/ready stream,
// issuing reads only while every in-flight word is guaranteed a skid slot.
module fifo_read_stream_adapter
  import fifo_read_stream_adapter_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned READ_LATENCY = HARD_FIFO_READ_LATENCY,
  parameter int unsigned SKID_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_underflow,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             protocol_err
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH) + 1;
  localparam int unsigned SUM_W = $clog2(SKID_DEPTH + READ_LATENCY + 1);

  if (READ_LATENCY < 1) begin : g_bad_latency
    $fatal(1, "fifo_read_stream_adapter: READ_LATENCY must be >= 1");
  end
  if (SKID_DEPTH < READ_LATENCY + 1) begin : g_bad_skid
    $fatal(1, "fifo_read_stream_adapter: SKID_DEPTH must be >= READ_LATENCY+1");
  end
  if (!is_pow2(SKID_DEPTH)) begin : g_bad_pow2
    $fatal(1, "fifo_read_stream_adapter: SKID_DEPTH must be a power of two");
  end

  logic [READ_LATENCY-1:0] r_inflight;
  logic                    r_protocol_err;

  logic [SUM_W-1:0]        w_inflight_cnt;
  logic [SUM_W-1:0]        w_credit_used;
  logic [CNT_W-1:0]        w_occ;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_overflow;

  // Credits in use: reads still in the FIFO pipeline plus words held in the skid.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      w_inflight_cnt = w_inflight_cnt + SUM_W'(r_inflight[i]);
    end
    w_credit_used = w_inflight_cnt + SUM_W'(w_occ);
  end

  // Same-cycle pop is deliberately not credited to keep fifo_empty the only fast path.
  assign fifo_rd_en = !rst && !fifo_empty && (w_credit_used < SUM_W'(SKID_DEPTH));
  assign w_push     = r_inflight[READ_LATENCY-1];
  assign w_pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_inflight <= (r_inflight << 1) | READ_LATENCY'(fifo_rd_en);
      if (fifo_underflow || w_overflow) r_protocol_err <= 1'b1;
    end
  end

  stream_skid_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_push       (w_push),
    .i_push_data  (fifo_rd_data),
    .i_pop        (w_pop),
    .o_valid      (out_valid),
    .o_head       (out_data),
    .o_occ        (w_occ),
    .o_overflow_c (w_overflow)
  );

  assign protocol_err = r_protocol_err;

endmodule
